// File: rtl/cpu_mem_requester.sv
`default_nettype none
// =============================================================================
// cpu_mem_requester: queues CPU load/store ops and issues them one at a time
// on the cache CPU port (level-held read/write, single-cycle ready). Rev 1.0
// =============================================================================
module cpu_mem_requester #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_error,
    output logic [31:0] rsp_data,
    output logic [31:0] cpu_addr,
    output logic [31:0] cpu_data_in,
    output logic        cpu_read,
    output logic        cpu_write,
    input  logic [31:0] cpu_data_out,
    input  logic        cpu_ready,
    output logic        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam int TO_LAST_I = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_LAST_I[TO_W-1:0];
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:2]      fifo_addr  [FIFO_DEPTH];
    logic [31:0]      fifo_wdata [FIFO_DEPTH];
    logic             fifo_write [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TO_W-1:0]  to_cnt;

    logic push;
    logic launch;
    logic complete;
    logic timeout;
    logic fifo_empty;
    logic addr_lsb_unused;

    // The cache is word addressed; byte offset bits are dropped.
    assign addr_lsb_unused = ^req_addr[1:0];

    assign fifo_empty = (count == '0);
    assign req_ready  = (count != FULL_CNT);
    assign push       = req_valid && req_ready;
    assign busy       = !fifo_empty || (state == S_ISSUE);

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    launch    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cpu_ready) begin
                    complete = 1'b1;
                    if (!fifo_empty) begin
                        launch = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    timeout   = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, launch})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= req_addr[31:2];
            fifo_wdata[wr_ptr] <= req_wdata;
            fifo_write[wr_ptr] <= req_write;
        end
    end

    // Launch has priority so a completing op hands straight over to the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_addr    <= '0;
            cpu_data_in <= '0;
            cpu_read    <= 1'b0;
            cpu_write   <= 1'b0;
            to_cnt      <= '0;
        end else if (launch) begin
            cpu_addr    <= {fifo_addr[rd_ptr], 2'b00};
            cpu_data_in <= fifo_wdata[rd_ptr];
            cpu_read    <= !fifo_write[rd_ptr];
            cpu_write   <= fifo_write[rd_ptr];
            to_cnt      <= '0;
        end else if (complete || timeout) begin
            cpu_read    <= 1'b0;
            cpu_write   <= 1'b0;
        end else if (state == S_ISSUE) begin
            to_cnt      <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_error <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= complete || timeout;
            if (complete) begin
                rsp_write <= cpu_write;
                rsp_error <= 1'b0;
                rsp_data  <= cpu_write ? 32'h0 : cpu_data_out;
            end else if (timeout) begin
                rsp_write <= cpu_write;
                rsp_error <= 1'b1;
                rsp_data  <= '0;
            end else begin
                rsp_write <= 1'b0;
                rsp_error <= 1'b0;
                rsp_data  <= '0;
            end
        end
    end

endmodule
`default_nettype wire
